// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths and auto-reset mode constants for the DSP slice datapath
package dsp_pkg;
    localparam int P_W = 48;
    localparam int A_W = 30;
    localparam int B_W = 18;
    localparam int AR_OFF      = 0;
    localparam int AR_MATCH    = 1;
    localparam int AR_NOTMATCH = 2;
endpackage

// File: rtl/p_out_stage_pattern_detect.sv
// pattern_detect: masked compare of a P value against a pattern and its complement
module pattern_detect
    import dsp_pkg::*;
(
    input  logic [P_W-1:0] value,
    input  logic [P_W-1:0] pattern,
    input  logic [P_W-1:0] mask,
    output logic           pd,
    output logic           pbd
);
    assign pd  = &(~(value ^ pattern) | mask);
    assign pbd = &(~(value ^ ~pattern) | mask);
endmodule

// File: rtl/p_out_stage.sv
// p_out_stage: registered P output with A/B split, pattern detect, overflow/underflow and auto-reset
module p_out_stage
    import dsp_pkg::*;
#(
    parameter int             PREG             = 1,
    parameter logic [P_W-1:0] PATTERN          = 48'h0000_0000_0000,
    parameter logic [P_W-1:0] MASK             = 48'h3FFF_FFFF_FFFF,
    parameter int             AUTORESET_PATDET = AR_OFF
)(
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           CEP,
    input  logic           RSTP,
    input  logic [P_W-1:0] ALU_OUT,
    output logic [P_W-1:0] P,
    output logic [A_W-1:0] P_A,
    output logic [B_W-1:0] P_B,
    output logic           PATTERN_DETECT,
    output logic           PATTERN_B_DETECT,
    output logic           PATTERN_DETECT_PAST,
    output logic           PATTERN_B_DETECT_PAST,
    output logic           OVERFLOW,
    output logic           UNDERFLOW
);
    logic [P_W-1:0] p_q, p_next, det_in;
    logic           pd_q, pbd_q, pd_n, pbd_n, pdp_q, pbdp_q, ar, upd;

    // auto-reset looks only at registered state, so it never forms a loop through the compare
    always_comb begin
        ar     = (PREG == 1) && (AUTORESET_PATDET == AR_MATCH    ? pd_q :
                                 AUTORESET_PATDET == AR_NOTMATCH ? (pdp_q && !pd_q) : 1'b0);
        upd    = RSTP || ar || CEP;
        p_next = (RSTP || ar) ? '0 : CEP ? ALU_OUT : p_q;
        det_in = (PREG == 1) ? p_next : ALU_OUT;
    end

    pattern_detect u_det (
        .value   (det_in),
        .pattern (PATTERN),
        .mask    (MASK),
        .pd      (pd_n),
        .pbd     (pbd_n)
    );

    // P and its detect bits move together so registered detect always describes registered P
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_q   <= '0;
            pd_q  <= 1'b0;
            pbd_q <= 1'b0;
        end else if (upd) begin
            p_q   <= p_next;
            pd_q  <= pd_n;
            pbd_q <= pbd_n;
        end
    end

    // past-detect history advances on any enabled or cleared cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pdp_q  <= 1'b0;
            pbdp_q <= 1'b0;
        end else if (CEP || RSTP) begin
            pdp_q  <= !RSTP && PATTERN_DETECT;
            pbdp_q <= !RSTP && PATTERN_B_DETECT;
        end
    end

    assign P                     = (PREG == 1) ? p_q : ALU_OUT;
    assign P_A                   = P[P_W-1:B_W];
    assign P_B                   = P[B_W-1:0];
    assign PATTERN_DETECT        = (PREG == 1) ? pd_q : pd_n;
    assign PATTERN_B_DETECT      = (PREG == 1) ? pbd_q : pbd_n;
    assign PATTERN_DETECT_PAST   = pdp_q;
    assign PATTERN_B_DETECT_PAST = pbdp_q;
    assign OVERFLOW              = pdp_q && !PATTERN_DETECT && !PATTERN_B_DETECT;
    assign UNDERFLOW             = pbdp_q && !PATTERN_DETECT && !PATTERN_B_DETECT;
endmodule

// File: tb/tb_p_out_stage.sv
// tb_p_out_stage: randomized and directed checks of four p_out_stage configurations against a behavioural model
module tb_p_out_stage;
    import dsp_pkg::*;

    localparam int N = 4;

    function automatic int preg_of(int i);
        return (i == 2) ? 0 : 1;
    endfunction
    function automatic int ar_of(int i);
        return (i == 1) ? 1 : (i == 3) ? 2 : 0;
    endfunction
    function automatic logic [47:0] pat_of(int i);
        return (i == 1 || i == 3) ? 48'd100 : 48'h0;
    endfunction
    function automatic logic [47:0] mask_of(int i);
        return (i == 1 || i == 3) ? 48'h0 : 48'h3FFF_FFFF_FFFF;
    endfunction

    logic        clk = 1'b0, rst_n = 1'b1, cep = 1'b1, rstp = 1'b0, chk_on = 1'b0;
    logic [47:0] alu = 48'h1234;
    logic [47:0] p [N];
    logic [29:0] pa [N];
    logic [17:0] pb [N];
    logic        pd [N], pbd [N], pdp [N], pbdp [N], ov [N], un [N];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        p_out_stage #(
            .PREG             (preg_of(g)),
            .PATTERN          (pat_of(g)),
            .MASK             (mask_of(g)),
            .AUTORESET_PATDET (ar_of(g))
        ) dut (
            .CLK                   (clk),
            .RST_N                 (rst_n),
            .CEP                   (cep),
            .RSTP                  (rstp),
            .ALU_OUT               (alu),
            .P                     (p[g]),
            .P_A                   (pa[g]),
            .P_B                   (pb[g]),
            .PATTERN_DETECT        (pd[g]),
            .PATTERN_B_DETECT      (pbd[g]),
            .PATTERN_DETECT_PAST   (pdp[g]),
            .PATTERN_B_DETECT_PAST (pbdp[g]),
            .OVERFLOW              (ov[g]),
            .UNDERFLOW             (un[g])
        );
    end

    logic [47:0] m_p [N];
    logic        m_pd [N], m_pbd [N], m_pdp [N], m_pbdp [N];

    function automatic logic match(logic [47:0] v, logic [47:0] pat, logic [47:0] msk);
        return &(~(v ^ pat) | msk);
    endfunction
    function automatic logic [47:0] exp_p(int i);
        return preg_of(i) == 1 ? m_p[i] : alu;
    endfunction
    function automatic logic exp_pd(int i);
        return preg_of(i) == 1 ? m_pd[i] : match(alu, pat_of(i), mask_of(i));
    endfunction
    function automatic logic exp_pbd(int i);
        return preg_of(i) == 1 ? m_pbd[i] : match(alu, ~pat_of(i), mask_of(i));
    endfunction

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            m_p[i] = '0; m_pd[i] = 1'b0; m_pbd[i] = 1'b0; m_pdp[i] = 1'b0; m_pbdp[i] = 1'b0;
        end
    endtask

    task automatic step();
        logic cpd, cpbd, ar;
        if (!rst_n) return;
        for (int i = 0; i < N; i++) begin
            cpd  = exp_pd(i);
            cpbd = exp_pbd(i);
            ar   = preg_of(i) == 1 && (ar_of(i) == 1 ? cpd : ar_of(i) == 2 ? (m_pdp[i] && !cpd) : 1'b0);
            if (cep || rstp) begin
                m_pdp[i]  = !rstp && cpd;
                m_pbdp[i] = !rstp && cpbd;
            end
            if (preg_of(i) == 1 && (rstp || ar || cep)) begin
                m_p[i]   = (rstp || ar) ? 48'h0 : alu;
                m_pd[i]  = match(m_p[i], pat_of(i), mask_of(i));
                m_pbd[i] = match(m_p[i], ~pat_of(i), mask_of(i));
            end
        end
    endtask

    task automatic chk(input string n, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rn, input logic c, input logic r, input logic [47:0] a);
        #1;
        rst_n = rn; cep = c; rstp = r; alu = a;
        if (!rn) clear();
        @(posedge clk);
        step();
        @(negedge clk);
    endtask

    // compare every instance against the model on each falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N; i++) begin
                logic [47:0] e;
                logic        epd, epbd;
                e    = exp_p(i);
                epd  = exp_pd(i);
                epbd = exp_pbd(i);
                chk($sformatf("u%0d_P", i), p[i], e);
                chk($sformatf("u%0d_P_A", i), 48'(pa[i]), 48'(e[47:18]));
                chk($sformatf("u%0d_P_B", i), 48'(pb[i]), 48'(e[17:0]));
                chk($sformatf("u%0d_PD", i), 48'(pd[i]), 48'(epd));
                chk($sformatf("u%0d_PBD", i), 48'(pbd[i]), 48'(epbd));
                chk($sformatf("u%0d_PDP", i), 48'(pdp[i]), 48'(m_pdp[i]));
                chk($sformatf("u%0d_PBDP", i), 48'(pbdp[i]), 48'(m_pbdp[i]));
                chk($sformatf("u%0d_OVF", i), 48'(ov[i]), 48'(m_pdp[i] && !epd && !epbd));
                chk($sformatf("u%0d_UNF", i), 48'(un[i]), 48'(m_pbdp[i] && !epd && !epbd));
            end
        end
    end

    initial begin
        logic [47:0] a;
        clear();
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_P", p[0], 48'h0);
        chk("rst_PD", 48'(pd[0]), 48'h0);
        chk("rst_OVF", 48'(ov[0]), 48'h0);
        chk("rst_UNF", 48'(un[0]), 48'h0);
        cyc(1, 1, 0, 48'h1234);
        chk("release_load_P", p[0], 48'h1234);
        cyc(1, 1, 0, 48'h0000_0004_0003);
        chk("split_P", p[0], 48'h40003);
        chk("split_P_A", 48'(pa[0]), 48'h1);
        chk("split_P_B", 48'(pb[0]), 48'h3);
        cyc(1, 0, 0, 48'hABC_DEF);
        chk("hold_P", p[0], 48'h40003);
        cyc(1, 1, 0, 48'h5);
        chk("ovf_pre_PD", 48'(pd[0]), 48'h1);
        cyc(1, 1, 0, 48'h4000_0000_0000);
        chk("ovf_PD", 48'(pd[0]), 48'h0);
        chk("ovf_PBD", 48'(pbd[0]), 48'h0);
        chk("ovf_PDP", 48'(pdp[0]), 48'h1);
        chk("ovf_OVF", 48'(ov[0]), 48'h1);
        chk("ovf_UNF", 48'(un[0]), 48'h0);
        cyc(1, 1, 0, 48'hFFFF_FFFF_FFFF);
        chk("unf_pre_PBD", 48'(pbd[0]), 48'h1);
        cyc(1, 1, 0, 48'h8000_0000_0000);
        chk("unf_UNF", 48'(un[0]), 48'h1);
        chk("unf_OVF", 48'(ov[0]), 48'h0);
        cyc(1, 1, 0, 48'd100);
        chk("ar_load_P", p[1], 48'd100);
        chk("ar_PD", 48'(pd[1]), 48'h1);
        cyc(1, 0, 0, 48'h7);
        chk("ar_clear_P", p[1], 48'h0);
        chk("ar_other_hold_P", p[0], 48'd100);
        cyc(1, 1, 0, 48'h7);
        cyc(1, 1, 1, 48'h7);
        chk("rstp_P", p[0], 48'h0);
        chk("rstp_PDP", 48'(pdp[0]), 48'h0);
        chk("rstp_PBDP", 48'(pbdp[0]), 48'h0);
        chk("preg0_P", p[2], 48'h7);
        #1 alu = 48'h55;
        #1 chk("preg0_comb_P", p[2], 48'h55);
        @(negedge clk);
        cyc(1, 1, 0, 48'h99);
        #1 rst_n = 1'b0;
        clear();
        #1 chk("async_P", p[0], 48'h0);
        chk("async_PD", 48'(pd[0]), 48'h0);
        @(negedge clk);
        repeat (3000) begin
            case ($urandom_range(7))
                0: a = 48'd100;
                1: a = 48'hFFFF_FFFF_FFFF;
                2: a = 48'h8000_0000_0000;
                3: a = 48'h4000_0000_0000;
                4: a = 48'($urandom_range(7));
                5: a = 48'h0;
                default: a = {16'($urandom()), 32'($urandom())};
            endcase
            cyc($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(15) == 0, a);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
